ir_fetch_unit: RTL and testbench

- Instruction fetch and sequencing stage directly upstream of the microinstruction decoder.
- Holds the 12-bit program counter, reads 24-bit instruction words from synchronous program memory, and presents them on `IR` to the decoder.
- Resolves group-0 flow-control instructions: JMP, JZE, JNE, JCY, BSR and RET. BSR and RET use a hardware return stack.

---
 rtl/ir_fetch_unit.sv | 193 +++++++++++++++++++
 tb/tb_ir_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_unit.sv
// ----------------------------------------------------------------------------
// ir_fetch_unit
// Instruction fetch and sequencing stage in front of the microinstruction
// decoder. It holds the program counter, reads 24-bit words from synchronous
// program memory, presents them on IR and resolves group-0 flow control
// (JMP, JZE, JNE, JCY, BSR, RET) using a hardware return stack.
//
// Sequence per instruction: FETCH -> WAIT -> LOAD -> EXEC x EXEC_CYCLES.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   reset_n     in   1   asynchronous active-low reset
//   pm_addr     out  12  program memory read address
//   pm_rd       out  1   read strobe; pm_data valid on the edge after it
//   pm_data     in   24  instruction word from program memory
//   zero_flag   in   1   Z flag, sampled in LOAD
//   carry_flag  in   1   CY flag, sampled in LOAD
//   stall       in   1   holds the unit in FETCH while high
//   IR          out  24  current instruction to the decoder
//   ir_valid    out  1   one-cycle pulse when IR is loaded
//   pc          out  12  address the current IR was fetched from
//   stack_ovf   out  1   sticky, BSR issued with a full stack
//   stack_unf   out  1   sticky, RET issued with an empty stack
// ----------------------------------------------------------------------------
module ir_fetch_unit #(
    parameter logic [11:0] RESET_PC    = 12'h000,
    parameter int          EXEC_CYCLES = 2,
    parameter int          STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [11:0] pm_addr,
    output logic        pm_rd,
    input  logic [23:0] pm_data,
    input  logic        zero_flag,
    input  logic        carry_flag,
    input  logic        stall,
    output logic [23:0] IR,
    output logic        ir_valid,
    output logic [11:0] pc,
    output logic        stack_ovf,
    output logic        stack_unf
);

    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = AW + 1;
    localparam int CW  = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    localparam logic [CW-1:0]  EXEC_LAST = CW'(EXEC_CYCLES - 1);
    localparam logic [SPW-1:0] SP_FULL   = SPW'(STACK_DEPTH);
    localparam logic [23:0]    NOP_WORD  = 24'h080000;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_LOAD  = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    state_t          r_state;
    logic [11:0]     r_fetch_pc;   // address of the instruction being fetched / executed
    logic [11:0]     r_next_pc;    // resolved successor, applied at the end of EXEC
    logic [CW-1:0]   r_exec_cnt;
    logic [SPW-1:0]  r_sp;         // counts 0..STACK_DEPTH
    logic [11:0]     r_stack [STACK_DEPTH];

    logic [11:0]     w_seq_pc;
    logic [11:0]     w_target;
    logic [7:0]      w_index;
    logic            w_is_flow;
    logic            w_empty;
    logic            w_full;
    logic [AW-1:0]   w_top_idx;
    logic [11:0]     w_next_pc;
    logic            w_push;
    logic            w_pop;
    logic            w_set_ovf;
    logic            w_set_unf;

    // Next-PC and return-stack decision for the word arriving in LOAD
    always_comb begin
        w_seq_pc  = r_fetch_pc + 12'd1;
        w_target  = pm_data[11:0];
        w_index   = pm_data[19:12];
        w_is_flow = (pm_data[23:19] == 5'b10000);
        w_empty   = (r_sp == {SPW{1'b0}});
        w_full    = (r_sp == SP_FULL);
        // Wraps correctly at full (pointer low bits are zero there)
        w_top_idx = r_sp[AW-1:0] - AW'(1);
        w_next_pc = w_seq_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (w_is_flow) begin
            case (w_index)
                8'd0: w_next_pc = w_target;
                8'd1: w_next_pc = zero_flag  ? w_target : w_seq_pc;
                8'd2: w_next_pc = !zero_flag ? w_target : w_seq_pc;
                8'd3: w_next_pc = carry_flag ? w_target : w_seq_pc;
                8'd4: begin
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_next_pc = r_stack[w_top_idx];
                    end else begin
                        w_set_unf = 1'b1;
                        w_next_pc = w_seq_pc;
                    end
                end
                8'd5: begin
                    w_next_pc = w_target;
                    if (!w_full) begin
                        w_push = 1'b1;
                    end else begin
                        w_set_ovf = 1'b1;
                    end
                end
                default: w_next_pc = w_seq_pc;
            endcase
        end else begin
            w_next_pc = w_seq_pc;
        end
    end

    // Fetch sequencer, registered outputs and return stack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_next_pc  <= RESET_PC;
            r_exec_cnt <= {CW{1'b0}};
            r_sp       <= {SPW{1'b0}};
            for (int i = 0; i < STACK_DEPTH; i++) begin
                r_stack[i] <= 12'h000;
            end
            pm_addr    <= RESET_PC;
            pm_rd      <= 1'b0;
            IR         <= NOP_WORD;
            ir_valid   <= 1'b0;
            pc         <= RESET_PC;
            stack_ovf  <= 1'b0;
            stack_unf  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (stall) begin
                        pm_rd <= 1'b0;
                    end else begin
                        pm_addr <= r_fetch_pc;
                        pm_rd   <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    pm_rd   <= 1'b0;
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    IR         <= pm_data;
                    ir_valid   <= 1'b1;
                    // pc tracks the IR, so it moves with the load, not the fetch
                    pc         <= r_fetch_pc;
                    r_next_pc  <= w_next_pc;
                    r_exec_cnt <= {CW{1'b0}};
                    if (w_push) begin
                        r_stack[r_sp[AW-1:0]] <= w_seq_pc;
                        r_sp <= r_sp + SPW'(1);
                    end else if (w_pop) begin
                        r_sp <= r_sp - SPW'(1);
                    end
                    stack_ovf  <= stack_ovf | w_set_ovf;
                    stack_unf  <= stack_unf | w_set_unf;
                    r_state    <= S_EXEC;
                end
                S_EXEC: begin
                    ir_valid <= 1'b0;
                    if (r_exec_cnt == EXEC_LAST) begin
                        r_fetch_pc <= r_next_pc;
                        r_state    <= S_FETCH;
                    end else begin
                        r_exec_cnt <= r_exec_cnt + CW'(1);
                    end
                end
                default: begin
                    pm_rd    <= 1'b0;
                    ir_valid <= 1'b0;
                    r_state  <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_fetch_unit.sv
// ----------------------------------------------------------------------------
// Testbench for ir_fetch_unit. A behavioural memory feeds the DUT; a reference
// model (expected PC plus a queue as the return stack) predicts every fetch
// address, IR, pc and sticky flag from the instruction semantics.
// ----------------------------------------------------------------------------
module tb_ir_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] pm_addr;
    logic        pm_rd;
    logic [23:0] pm_data = 24'h000000;
    logic        zero_flag;
    logic        carry_flag;
    logic        stall;
    logic [23:0] IR;
    logic        ir_valid;
    logic [11:0] pc;
    logic        stack_ovf;
    logic        stack_unf;

    always #5 clk = ~clk;

    ir_fetch_unit #(
        .RESET_PC   (12'h000),
        .EXEC_CYCLES(2),
        .STACK_DEPTH(8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pm_addr   (pm_addr),
        .pm_rd     (pm_rd),
        .pm_data   (pm_data),
        .zero_flag (zero_flag),
        .carry_flag(carry_flag),
        .stall     (stall),
        .IR        (IR),
        .ir_valid  (ir_valid),
        .pc        (pc),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf)
    );

    logic [23:0] mem [0:4095];

    // Synchronous program memory: data valid on the edge after the strobe
    always @(posedge clk) begin
        if (pm_rd) pm_data <= mem[pm_addr];
    end

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_pc;
    logic [11:0] stk [$];
    logic        m_ovf;
    logic        m_unf;
    longint      last_rd;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] enc(input logic [7:0] idx, input logic [11:0] tgt);
        return {4'h8, idx, tgt};
    endfunction

    // Run one instruction through the DUT and advance the reference model
    task automatic step_instr(input logic z, input logic c, input int exp_gap);
        int          n;
        logic [23:0] instr;
        logic [11:0] seq;
        logic [11:0] nxt;
        zero_flag  = z;
        carry_flag = c;
        n = 0;
        while (pm_rd !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("pm_rd_seen", {23'd0, pm_rd}, 24'd1);
        check("pm_addr", {12'd0, pm_addr}, {12'd0, exp_pc});
        if (exp_gap > 0) check("fetch_gap", 24'(($time - last_rd) / 10), 24'(exp_gap));
        last_rd = $time;
        @(negedge clk);
        check("ir_valid_wait", {23'd0, ir_valid}, 24'd0);
        @(negedge clk);
        instr = mem[exp_pc];
        check("ir_valid_load", {23'd0, ir_valid}, 24'd1);
        check("IR", IR, instr);
        check("pc", {12'd0, pc}, {12'd0, exp_pc});
        // Reference semantics
        seq = exp_pc + 12'd1;
        nxt = seq;
        if (instr[23:19] == 5'b10000) begin
            if (instr[19:12] == 8'd0) nxt = instr[11:0];
            if (instr[19:12] == 8'd1 && z)  nxt = instr[11:0];
            if (instr[19:12] == 8'd2 && !z) nxt = instr[11:0];
            if (instr[19:12] == 8'd3 && c)  nxt = instr[11:0];
            if (instr[19:12] == 8'd4) begin
                if (stk.size() > 0) nxt = stk.pop_back();
                else m_unf = 1'b1;
            end
            if (instr[19:12] == 8'd5) begin
                if (stk.size() < 8) stk.push_back(seq);
                else m_ovf = 1'b1;
                nxt = instr[11:0];
            end
        end
        check("stack_ovf", {23'd0, stack_ovf}, {23'd0, m_ovf});
        check("stack_unf", {23'd0, stack_unf}, {23'd0, m_unf});
        @(negedge clk);
        check("ir_valid_pulse_end", {23'd0, ir_valid}, 24'd0);
        check("IR_held", IR, instr);
        exp_pc = nxt;
    endtask

    initial begin
        logic [10:0] dz;
        logic [10:0] dc;
        logic [23:0] w;
        int          kind;
        logic [11:0] tgt;

        dz = 11'h018;
        dc = 11'h080;

        for (int i = 0; i < 4096; i++) mem[i] = 24'h400000;
        mem[12'h005] = 24'h800123;
        mem[12'h123] = 24'h801040;
        mem[12'h124] = 24'h800123;
        mem[12'h040] = 24'h802060;
        mem[12'h041] = 24'h800040;
        mem[12'h060] = 24'h803010;
        mem[12'h010] = 24'h805200;
        mem[12'h200] = 24'h804000;
        mem[12'h011] = 24'h800300;
        for (int i = 0; i < 9; i++) begin
            mem[12'h300 + 12'(16 * i)] = enc(8'd5, 12'h310 + 12'(16 * i));
        end
        mem[12'h390] = enc(8'd4, 12'h000);
        for (int i = 0; i < 8; i++) mem[12'h301 + 12'(16 * i)] = enc(8'd4, 12'h000);
        mem[12'h302] = 24'h800FFE;
        // Random program region
        for (int a = 12'h400; a < 12'h500; a++) begin
            kind = $urandom_range(0, 9);
            tgt  = 12'h400 + 12'($urandom_range(0, 255));
            if (kind <= 5) begin
                mem[a] = enc(8'(kind), tgt);
            end else if (kind == 6) begin
                mem[a] = enc(8'($urandom_range(6, 127)), tgt);
            end else begin
                w = 24'($urandom);
                if (w[23:19] == 5'b10000) w[23] = 1'b0;
                mem[a] = w;
            end
        end

        // Reset state
        reset_n    = 1'b0;
        stall      = 1'b0;
        zero_flag  = 1'b0;
        carry_flag = 1'b0;
        exp_pc     = 12'h000;
        m_ovf      = 1'b0;
        m_unf      = 1'b0;
        last_rd    = 0;
        repeat (3) @(negedge clk);
        check("rst_pc", {12'd0, pc}, 24'h000000);
        check("rst_pm_addr", {12'd0, pm_addr}, 24'h000000);
        check("rst_pm_rd", {23'd0, pm_rd}, 24'd0);
        check("rst_IR", IR, 24'h080000);
        check("rst_ir_valid", {23'd0, ir_valid}, 24'd0);
        check("rst_ovf", {23'd0, stack_ovf}, 24'd0);
        check("rst_unf", {23'd0, stack_unf}, 24'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("first_rd_after_reset", {23'd0, pm_rd}, 24'd1);

        // Sequential fetches, then JMP/JZE/JNE/JCY/BSR/RET directed path
        step_instr(1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) step_instr(1'b0, 1'b0, 5);
        for (int i = 0; i < 11; i++) step_instr(dz[i], dc[i], 5);
        // Nine nested BSRs, nine RETs
        for (int i = 0; i < 18; i++) step_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5);
        // JMP 0xFFE, 0xFFE, 0xFFF (wraps)
        for (int i = 0; i < 3; i++) step_instr(1'b0, 1'b0, 5);

        // Stall in FETCH for 4 cycles
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_no_rd", {23'd0, pm_rd}, 24'd0);
        end
        stall = 1'b0;
        mem[12'h001] = 24'h800400;
        step_instr(1'b0, 1'b0, 9);
        step_instr(1'b0, 1'b0, 5);

        // Randomized program and flags
        for (int i = 0; i < 80; i++) begin
            step_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5);
        end

        // Reset during EXEC right after a BSR push
        mem[exp_pc] = enc(8'd5, 12'h700);
        step_instr(1'b0, 1'b0, 5);
        #2 reset_n = 1'b0;
        #1;
        check("arst_pc", {12'd0, pc}, 24'h000000);
        check("arst_pm_addr", {12'd0, pm_addr}, 24'h000000);
        check("arst_pm_rd", {23'd0, pm_rd}, 24'd0);
        check("arst_IR", IR, 24'h080000);
        check("arst_ir_valid", {23'd0, ir_valid}, 24'd0);
        check("arst_ovf", {23'd0, stack_ovf}, 24'd0);
        check("arst_unf", {23'd0, stack_unf}, 24'd0);
        mem[12'h000] = enc(8'd4, 12'h000);
        exp_pc = 12'h000;
        stk.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("first_rd_after_arst", {23'd0, pm_rd}, 24'd1);
        // RET at RESET_PC must see an empty stack
        step_instr(1'b0, 1'b0, 0);
        step_instr(1'b0, 1'b0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
